// File: rtl/dvp_frame_tx.sv
// DVP transmit raster generator: FIFO bytes out as vsync/href/data, 2-cycle aligned.
// Optional ramp source enabled by defining DVP_TX_TEST_PATTERN_EN.
module dvp_frame_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10
) (
    input  logic       sck,
    input  logic       rst,
    input  logic       tx_enable,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_rd_data,
`ifdef DVP_TX_TEST_PATTERN_EN
    input  logic       test_pattern,
`endif
    output logic       cmos_vsync,
    output logic       cmos_href,
    output logic [7:0] cmos_data,
    output logic       frame_done,
    output logic       underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VM_A = (V_SYNC > V_BP) ? V_SYNC : V_BP;
    localparam int VM_B = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
    localparam int VMAX = (VM_A > VM_B) ? VM_A : VM_B;
    localparam int VW = (VMAX > 1) ? $clog2(VMAX) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] VS_LAST = VW'(V_SYNC - 1);
    localparam logic [VW-1:0] VB_LAST = VW'(V_BP - 1);
    localparam logic [VW-1:0] VA_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VF_LAST = VW'(V_FP - 1);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        ACTIVE,
        VFP
    } state_t;

    state_t state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [VW-1:0] v_last;
    logic line_end;
    logic frame_end;
    logic enter_vs;
    logic vs_pre;
    logic hr_pre;
    logic pat_mode;
    logic underrun_q, underrun_d;

    logic vs1_q, hr1_q, rd1_q;
    logic vs2_q, hr2_q;
    logic [7:0] data2_q, data2_d;

`ifdef DVP_TX_TEST_PATTERN_EN
    logic pat_q, pat_d;
    logic pt1_q;
    logic [7:0] ramp1_q;
`endif

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        frame_end = 1'b0;
        line_end  = (hcnt_q == H_LAST);
        case (state_q)
            VSYNC:   v_last = VS_LAST;
            VBP:     v_last = VB_LAST;
            ACTIVE:  v_last = VA_LAST;
            VFP:     v_last = VF_LAST;
            default: v_last = '0;
        endcase
        if (state_q == IDLE) begin
            hcnt_d = '0;
            vcnt_d = '0;
            if (tx_enable) begin
                state_d = VSYNC;
            end
        end else begin
            hcnt_d = line_end ? '0 : hcnt_q + HW'(1);
            if (line_end) begin
                if (vcnt_q == v_last) begin
                    vcnt_d = '0;
                    case (state_q)
                        VSYNC:  state_d = VBP;
                        VBP:    state_d = ACTIVE;
                        ACTIVE: state_d = VFP;
                        VFP: begin
                            frame_end = 1'b1;
                            state_d   = tx_enable ? VSYNC : IDLE;
                        end
                        default: state_d = IDLE;
                    endcase
                end else begin
                    vcnt_d = vcnt_q + VW'(1);
                end
            end
        end
    end

    assign enter_vs = (state_d == VSYNC) && (state_q != VSYNC);
    assign vs_pre   = (state_q == VSYNC);
    assign hr_pre   = (state_q == ACTIVE) && (hcnt_q < H_ACT);

`ifdef DVP_TX_TEST_PATTERN_EN
    // Source select is latched once per frame so a line never mixes sources.
    assign pat_d    = enter_vs ? test_pattern : pat_q;
    assign pat_mode = pat_q;
`else
    assign pat_mode = 1'b0;
`endif

    assign fifo_rd_en = hr_pre & ~fifo_empty & ~pat_mode;
    assign underrun_d = enter_vs ? 1'b0
                      : (underrun_q | (hr_pre & fifo_empty & ~pat_mode));

    // Stage 2 takes FIFO data only for bytes that were actually read.
    always_comb begin
        data2_d = 8'h00;
        if (hr1_q) begin
            if (rd1_q) begin
                data2_d = fifo_rd_data;
            end
`ifdef DVP_TX_TEST_PATTERN_EN
            if (pt1_q) begin
                data2_d = ramp1_q;
            end
`endif
        end
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            underrun_q <= 1'b0;
            vs1_q      <= 1'b0;
            hr1_q      <= 1'b0;
            rd1_q      <= 1'b0;
            vs2_q      <= 1'b0;
            hr2_q      <= 1'b0;
            data2_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            underrun_q <= underrun_d;
            vs1_q      <= vs_pre;
            hr1_q      <= hr_pre;
            rd1_q      <= fifo_rd_en;
            vs2_q      <= vs1_q;
            hr2_q      <= hr1_q;
            data2_q    <= data2_d;
        end
    end

`ifdef DVP_TX_TEST_PATTERN_EN
    always_ff @(posedge sck) begin
        if (rst) begin
            pat_q   <= 1'b0;
            pt1_q   <= 1'b0;
            ramp1_q <= 8'h00;
        end else begin
            pat_q   <= pat_d;
            pt1_q   <= hr_pre & pat_mode;
            ramp1_q <= 8'(hcnt_q);
        end
    end
`endif

    assign cmos_vsync = vs2_q;
    assign cmos_href  = hr2_q;
    assign cmos_data  = data2_q;
    assign frame_done = frame_end;
    assign underrun   = underrun_q;

endmodule

// File: doc/dvp_frame_tx.md
# dvp_frame_tx

Generates DVP-style camera timing (vsync, href, 8-bit data) on the pixel clock from bytes pulled out of a first-word-fall-through-free FIFO, i.e. the transmit counterpart of the capture path that aligns cmos_href/cmos_vsync/cmos_data ahead of the capture FIFO. Used to replay buffered audio-spectrum or image bytes to a downstream DVP sink or to loop back the capture path in test. The block is a raster counter FSM with a FIFO read port of 1-cycle read latency and a 2-stage output alignment pipeline.

## Interface
- H_ACTIVE, 640, bytes per line with href high
- H_BLANK, 144, href-low cycles after each active line
- V_SYNC, 3, lines with vsync high
- V_BP, 17, lines after vsync before first active line
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, lines after last active line

- sck  input  1  pixel clock
- rst  input  1  reset, synchronous, active-high
- tx_enable  input  1  run frames; sampled only at frame boundaries
- fifo_empty  input  1  source FIFO empty
- fifo_rd_en  output  1  FIFO read strobe; data on fifo_rd_data one cycle later
- fifo_rd_data  input  8  FIFO read data
- cmos_vsync  output  1  frame sync, active-high
- cmos_href  output  1  line valid, active-high
- cmos_data  output  8  pixel byte
- frame_done  output  1  one-cycle pulse at last cycle of V_FP
- underrun  output  1  sticky: active byte requested while FIFO empty

## Operation
- Line = H_TOTAL = H_ACTIVE+H_BLANK cycles; horizontal counter hcnt 0..H_TOTAL-1, wraps, increments vcnt.
- FSM states: IDLE, VSYNC (V_SYNC lines), VBP (V_BP lines), ACTIVE (V_ACTIVE lines), VFP (V_FP lines).
- IDLE -> VSYNC when tx_enable=1. VFP last cycle -> VSYNC if tx_enable=1, else IDLE. Deasserting tx_enable mid-frame finishes the current frame.
- Internal (pre-pipeline) signals: vs_pre=1 in VSYNC; hr_pre=1 in ACTIVE while hcnt<H_ACTIVE.
- fifo_rd_en = hr_pre & ~fifo_empty, combinational from registered state; never asserted outside hr_pre.
- If hr_pre=1 and fifo_empty=1: no read, that byte goes out as 8'h00, underrun set. underrun clears only on rst or on entering VSYNC.
- Outputs outside href-high cycles: cmos_data=8'h00.
- Counter widths: clog2 of largest range; no arithmetic overflow permitted for any legal parameter set (all parameters >=1).

## Timing
- Reset: state IDLE, counters 0, cmos_vsync=0, cmos_href=0, cmos_data=8'h00, fifo_rd_en=0, frame_done=0, underrun=0. Reset mid-frame aborts immediately; any in-flight read data is discarded.
- Latency: hr_pre/vs_pre in cycle t -> cmos_href/cmos_vsync at output in t+2; fifo_rd_en in t -> fifo_rd_data valid t+1 -> cmos_data registered, valid t+2. Data, href, vsync are exactly aligned.
- First cmos_vsync rise 2 cycles after the edge where IDLE exits.
- frame_done pulses in the cycle the FSM leaves VFP (pre-pipeline timebase, not delayed).
- Frame period = (V_SYNC+V_BP+V_ACTIVE+V_FP)*H_TOTAL cycles, back-to-back with no gap when tx_enable stays high.

## Configuration
- DVP_TX_TEST_PATTERN_EN defined: extra input test_pattern (1 bit, sampled at frame start). When 1, fifo_rd_en held 0, cmos_data = hcnt[7:0] of the byte (ramp 0,1,2...), underrun never sets. When 0, normal FIFO behaviour.
- Not defined: port absent, FIFO path only.

## Test plan
- Params H_ACTIVE=4,H_BLANK=2,V_SYNC=1,V_BP=1,V_ACTIVE=2,V_FP=1; FIFO preloaded 0x10..0x17, tx_enable=1 -> vsync high 6 cycles, two lines of href high 4 cycles carrying 0x10-0x13 then 0x14-0x17, frame_done every 30 cycles, underrun=0.
- Same, FIFO holds only 0x10-0x12 -> 4th byte of line 1 is 0x00, all of line 2 0x00, underrun=1 until next VSYNC entry; href shape unchanged.
- tx_enable dropped during ACTIVE line 1 -> frame completes, frame_done pulses, FSM IDLE, outputs stay 0.
- rst asserted for one cycle mid-line -> next cycle all outputs 0, fifo_rd_en=0; restart produces full frame from VSYNC.
- Check rd_en->data alignment: each cmos_data byte with href=1 equals the FIFO word read exactly 2 cycles earlier, 8 lines random data.
- With DVP_TX_TEST_PATTERN_EN, test_pattern=1, empty FIFO -> each line carries 0x00,0x01,0x02,0x03, fifo_rd_en never high, underrun=0.
